pulse_pair_gen: RTL and testbench
=================================

# pulse_pair_gen

Synthesizable START/STOP stimulus generator for TDC characterization. Clocked by the bench clock generator output, it emits pairs of pulses separated by a programmed number of clock cycles, optionally repeated with a programmed idle gap. Its outputs drive the TDC start and stop inputs directly and give a known-interval reference for calibration runs.

## Interface
- DELAY_WIDTH, 16, width of `delay` and `gap`, in clock cycles
- REP_WIDTH, 8, width of `reps` and `pair_cnt`
- PULSE_CYCLES, 2, high time of each start/stop pulse in cycles; must be ≥1
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- trig  in  1  one-cycle request to start a sequence; honoured only when `busy`=0
- delay  in  DELAY_WIDTH  cycles from start rising to stop rising
- gap  in  DELAY_WIDTH  idle cycles from stop falling to the next start rising
- reps  in  REP_WIDTH  number of pairs to emit
- start  out  1  START pulse, registered
- stop  out  1  STOP pulse, registered
- busy  out  1  sequence in progress
- done  out  1  one-cycle completion strobe
- pair_cnt  out  REP_WIDTH  pairs completed in current/last sequence

## Operation
- States: IDLE, ACTIVE (pair in flight), GAP (inter-pair idle), FINISH (done strobe).
- IDLE: on `trig`=1, latch `delay`, `gap` and `reps`, clear `pair_cnt`, go to ACTIVE. If `reps`=0, go to FINISH instead.
- ACTIVE phase counter t starts at 0 in the first ACTIVE cycle and increments every cycle.
  - start=1 for t in [0, PULSE_CYCLES).
  - stop=1 for t in [delay, delay+PULSE_CYCLES).
  - At t = delay+PULSE_CYCLES−1, `pair_cnt` increments.
  - Next state: GAP if pairs remain and gap>0; ACTIVE with t=0 if pairs remain and gap=0; otherwise FINISH.
- GAP: lasts exactly `gap` cycles, then ACTIVE with t=0.
- FINISH: `done`=1 for one cycle, then IDLE. No gap is inserted after the last pair.
- Pair period is P = delay + PULSE_CYCLES + gap.
- start and stop may overlap:
  - delay=0: start and stop are high in the same cycles.
  - delay<PULSE_CYCLES: pulses partially overlap.
- The phase counter is DELAY_WIDTH+2 bits wide; it never wraps, even with delay and gap both at maximum.
- `pair_cnt` saturates naturally at `reps` and holds its value in IDLE until the next accepted `trig`.
- `busy` is 1 in ACTIVE, GAP and FINISH.
- `trig` is ignored whenever `busy`=1, including the FINISH cycle.
- Inputs `delay`, `gap` and `reps` are only sampled at trig acceptance. Later changes do not affect a running sequence.

## Timing
- Reset values: start=0, stop=0, busy=0, done=0, pair_cnt=0, state IDLE.
- Reset mid-sequence: all outputs are at reset values after the next edge, and the sequence is abandoned.
- `trig` in the same cycle as `rst` is ignored.
- Latency: `trig` sampled at edge k; start and busy are high from edge k+1. This is the cycle index used by every cycle number in the test plan: trig accepted = cycle 0.
- With reps=N≥1:
  - Start n (0-based) rises at cycle 1+n·P.
  - Stop n rises at cycle 1+n·P+delay.
  - done is high at cycle 1+(N−1)·P+delay+PULSE_CYCLES.
  - busy falls the cycle after done.
- reps=0: busy=1 and done=1 in cycle 1 only; start and stop stay 0.
- Back-to-back sequences: a `trig` one cycle after `done` is accepted. There are no dead cycles beyond the FINISH cycle.

## Test plan
All scenarios use PULSE_CYCLES=2; cycle numbers are counted from trig = cycle 0.
- Reset: hold rst for 3 cycles with trig=1 → start, stop, busy and done stay 0; pair_cnt=0.
- Single pair, delay=5, gap=3, reps=1 → start high cycles 1–2; stop high 6–7; done at cycle 8; busy high 1–8; pair_cnt=1.
- Repeats, delay=4, gap=2, reps=3 (P=8) → start rises at 1, 9, 17; stop rises at 5, 13, 21; done at 23; pair_cnt steps 1→2→3.
- Overlap/zero cases:
  - delay=0 → start and stop both high in cycles 1–2.
  - delay=1 → start high 1–2, stop high 2–3, done at cycle 4.
  - gap=0, reps=2, delay=3 → second start rises at cycle 6.
- Handshake:
  - trig pulsed during busy and in the done cycle → ignored.
  - trig the cycle after done → new sequence starts next cycle.
  - reps=0 → busy and done high in cycle 1 only.
- Abort and extremes:
  - rst asserted at cycle 4 of a delay=10 sequence → all outputs 0 from the next cycle, and stop never asserts.
  - delay=gap=0xFFFF, reps=2 → second start rises at cycle 1+131072, with no counter wrap.

Source files
------------

// File: rtl/pulse_pair_gen.sv
// START/STOP pulse-pair generator for TDC characterisation: emits `reps` pairs
// of PULSE_CYCLES-wide pulses `delay` cycles apart, separated by `gap` idle cycles.
module pulse_pair_gen #(
  parameter int DELAY_WIDTH  = 16,
  parameter int REP_WIDTH    = 8,
  parameter int PULSE_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   trig,
  input  logic [DELAY_WIDTH-1:0] delay,
  input  logic [DELAY_WIDTH-1:0] gap,
  input  logic [REP_WIDTH-1:0]   reps,
  output logic                   start,
  output logic                   stop,
  output logic                   busy,
  output logic                   done,
  output logic [REP_WIDTH-1:0]   pair_cnt,
  output logic [1:0]             state_dbg
);

  // Two spare bits: the longest phase is delay+PULSE_CYCLES-1, which never wraps.
  localparam int TW = DELAY_WIDTH + 2;

  typedef enum logic [1:0] {IDLE, ACTIVE, GAP, FINISH} state_t;

  state_t                 state;
  logic [TW-1:0]          t;
  logic [DELAY_WIDTH-1:0] delay_q;
  logic [DELAY_WIDTH-1:0] gap_q;
  logic [REP_WIDTH-1:0]   reps_q;

  logic [TW-1:0]          dly_ext;
  logic [TW-1:0]          pair_last;
  logic [TW-1:0]          stop_end;
  logic [TW-1:0]          gap_last;
  logic [TW-1:0]          t_inc;
  logic [REP_WIDTH-1:0]   cnt_inc;
  logic                   more;

  assign dly_ext   = TW'(delay_q);
  assign pair_last = dly_ext + TW'(PULSE_CYCLES - 1);
  assign stop_end  = dly_ext + TW'(PULSE_CYCLES);
  assign gap_last  = TW'(gap_q) - TW'(1);
  assign t_inc     = t + TW'(1);
  assign cnt_inc   = pair_cnt + REP_WIDTH'(1);
  assign more      = cnt_inc < reps_q;
  assign state_dbg = state;

  // Handshake: trig is a single-cycle request accepted only on an edge where
  // busy=0 and rst=0; busy covers ACTIVE, GAP and the FINISH (done) cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      t        <= '0;
      delay_q  <= '0;
      gap_q    <= '0;
      reps_q   <= '0;
      start    <= 1'b0;
      stop     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pair_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          start <= 1'b0;
          stop  <= 1'b0;
          if (trig) begin
            delay_q  <= delay;
            gap_q    <= gap;
            reps_q   <= reps;
            pair_cnt <= '0;
            t        <= '0;
            busy     <= 1'b1;
            if (reps == '0) begin
              state <= FINISH;
              done  <= 1'b1;
            end else begin
              state <= ACTIVE;
              start <= 1'b1;
              stop  <= (delay == '0);
            end
          end
        end

        ACTIVE: begin
          if (t == pair_last) begin
            pair_cnt <= cnt_inc;
            t        <= '0;
            if (more && gap_q != '0) begin
              state <= GAP;
              start <= 1'b0;
              stop  <= 1'b0;
            end else if (more) begin
              start <= 1'b1;
              stop  <= (delay_q == '0);
            end else begin
              state <= FINISH;
              start <= 1'b0;
              stop  <= 1'b0;
              done  <= 1'b1;
            end
          end else begin
            t     <= t_inc;
            start <= (t_inc < TW'(PULSE_CYCLES));
            stop  <= (t_inc >= dly_ext) && (t_inc < stop_end);
          end
        end

        GAP: begin
          if (t == gap_last) begin
            state <= ACTIVE;
            t     <= '0;
            start <= 1'b1;
            stop  <= (delay_q == '0);
          end else begin
            t <= t_inc;
          end
        end

        FINISH: begin
          state <= IDLE;
          busy  <= 1'b0;
          start <= 1'b0;
          stop  <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_pair_gen.sv
// Bench for pulse_pair_gen: arithmetic timeline model checked every cycle,
// plus literal edge-time expectations for the directed scenarios.
module tb_pulse_pair_gen;

  // DELAY_WIDTH is reduced so the all-ones delay/gap case stays short.
  localparam int DW = 12;
  localparam int RW = 8;
  localparam int PC = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          trig;
  logic [DW-1:0] delay;
  logic [DW-1:0] gap;
  logic [RW-1:0] reps;
  logic          start;
  logic          stop;
  logic          busy;
  logic          done;
  logic [RW-1:0] pair_cnt;
  logic [1:0]    state_dbg;

  pulse_pair_gen #(.DELAY_WIDTH(DW), .REP_WIDTH(RW), .PULSE_CYCLES(PC)) dut (
    .clk(clk), .rst(rst), .trig(trig), .delay(delay), .gap(gap), .reps(reps),
    .start(start), .stop(stop), .busy(busy), .done(done),
    .pair_cnt(pair_cnt), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int base   = 0;
  int busy_cnt = 0;

  int start_q[$];
  int stop_q[$];
  int done_q[$];
  logic [31:0] exp_q[$];
  logic prev_start = 1'b0;
  logic prev_stop  = 1'b0;

  // Model: one accepted sequence described by its parameters and the index
  // of the cycle currently on the outputs (accepted trig = cycle 0).
  bit m_valid = 1'b0;
  int m_cur = 0;
  int md = 0;
  int mg = 0;
  int mn = 0;

  function automatic int m_p();
    return md + PC + mg;
  endfunction

  function automatic int m_end();
    return (mn == 0) ? 1 : 1 + (mn - 1) * m_p() + md + PC;
  endfunction

  function automatic bit e_busy();
    return m_valid && m_cur >= 1 && m_cur <= m_end();
  endfunction

  function automatic bit e_done();
    return m_valid && m_cur == m_end();
  endfunction

  function automatic int e_phase();
    return (m_cur - 1) % m_p();
  endfunction

  function automatic bit e_in_pairs();
    return m_valid && mn > 0 && m_cur >= 1 && m_cur < m_end();
  endfunction

  function automatic bit e_start();
    return e_in_pairs() && e_phase() < PC;
  endfunction

  function automatic bit e_stop();
    return e_in_pairs() && e_phase() >= md && e_phase() < md + PC;
  endfunction

  function automatic int e_cnt();
    int k;
    if (!m_valid || mn == 0 || m_cur < 1 + md + PC) return 0;
    k = (m_cur - 1 - md - PC) / m_p() + 1;
    return (k > mn) ? mn : k;
  endfunction

  always @(posedge clk) begin
    bit b;
    b = e_busy();
    cyc = cyc + 1;
    if (rst) begin
      m_valid = 1'b0;
    end else if (!b && trig) begin
      md = int'(delay);
      mg = int'(gap);
      mn = int'(reps);
      m_valid = 1'b1;
      m_cur = 1;
    end else if (m_valid) begin
      m_cur = m_cur + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    checks++;
    if (act !== 32'(exp)) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // Compare process: every cycle once the first edge has happened.
  always @(negedge clk) begin
    if (cyc > 0) begin
      chk("start", 32'(start), int'(e_start()));
      chk("stop", 32'(stop), int'(e_stop()));
      chk("busy", 32'(busy), int'(e_busy()));
      chk("done", 32'(done), int'(e_done()));
      chk("pair_cnt", 32'(pair_cnt), e_cnt());
      if (start === 1'b1 && prev_start !== 1'b1) start_q.push_back(cyc - base);
      if (stop === 1'b1 && prev_stop !== 1'b1) stop_q.push_back(cyc - base);
      if (done === 1'b1) done_q.push_back(cyc - base);
      if (busy === 1'b1) busy_cnt++;
      prev_start = start;
      prev_stop  = stop;
    end
  end

  task automatic chk_q(input string name, input int sel);
    int g[$];
    case (sel)
      0: g = start_q;
      1: g = stop_q;
      default: g = done_q;
    endcase
    checks++;
    if (g.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s count actual=%0d expected=%0d", name, g.size(), exp_q.size());
    end else begin
      foreach (g[i]) begin
        if (g[i] != int'(exp_q[i])) begin
          errors++;
          $display("FAIL %s edge %0d actual=%0d expected=%0d", name, i, g[i], exp_q[i]);
          break;
        end
      end
    end
  endtask

  task automatic clear_rec();
    start_q.delete();
    stop_q.delete();
    done_q.delete();
    busy_cnt = 0;
  endtask

  // Drive trig at cycle 0; returns during cycle 1 with inputs scrambled.
  task automatic fire(input int d, input int g, input int n);
    clear_rec();
    delay = DW'(d);
    gap   = DW'(g);
    reps  = RW'(n);
    trig  = 1'b1;
    base  = cyc;
    @(negedge clk);
    trig  = 1'b0;
    delay = DW'($urandom);
    gap   = DW'($urandom);
    reps  = RW'($urandom);
  endtask

  task automatic wait_idle(input int limit, input bit noise);
    int k;
    k = 0;
    while (e_busy() && k < limit) begin
      trig = noise ? ($urandom_range(0, 3) == 0) : 1'b0;
      @(negedge clk);
      k++;
    end
    trig = 1'b0;
    checks++;
    if (k >= limit) begin
      errors++;
      $display("FAIL wait_idle timeout after %0d cycles", k);
    end
    @(negedge clk);
  endtask

  task automatic run(input int d, input int g, input int n);
    fire(d, g, n);
    wait_idle(20000, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    trig = 1'b1;
    delay = DW'(5);
    gap = DW'(3);
    reps = RW'(1);
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_pair_cnt", 32'(pair_cnt), 0);
    rst = 1'b0;
    trig = 1'b0;
    repeat (2) @(negedge clk);

    run(5, 3, 1);
    exp_q = '{1};        chk_q("single_start", 0);
    exp_q = '{6};        chk_q("single_stop", 1);
    exp_q = '{8};        chk_q("single_done", 2);
    chk("single_busy_cycles", 32'(busy_cnt), 8);
    chk("single_pair_cnt", 32'(pair_cnt), 1);

    run(4, 2, 3);
    exp_q = '{1, 9, 17}; chk_q("rep_start", 0);
    exp_q = '{5, 13, 21}; chk_q("rep_stop", 1);
    exp_q = '{23};       chk_q("rep_done", 2);
    chk("rep_pair_cnt", 32'(pair_cnt), 3);

    run(0, 1, 1);
    exp_q = '{1};        chk_q("d0_start", 0);
    exp_q = '{1};        chk_q("d0_stop", 1);

    run(1, 0, 1);
    exp_q = '{2};        chk_q("d1_stop", 1);
    exp_q = '{4};        chk_q("d1_done", 2);

    run(3, 0, 2);
    exp_q = '{1, 6};     chk_q("g0_start", 0);

    run(7, 2, 0);
    exp_q = '{1};        chk_q("r0_done", 2);
    exp_q = '{};         chk_q("r0_start", 0);
    chk("r0_busy_cycles", 32'(busy_cnt), 1);

    // Handshake: trig at cycle 3 (busy) and 10 (done) ignored, 11 accepted.
    clear_rec();
    delay = DW'(2);
    gap = DW'(1);
    reps = RW'(2);
    trig = 1'b1;
    base = cyc;
    @(negedge clk);
    trig = 1'b0;
    repeat (2) @(negedge clk);
    trig = 1'b1;
    @(negedge clk);
    trig = 1'b0;
    repeat (6) @(negedge clk);
    trig = 1'b1;
    repeat (2) @(negedge clk);
    trig = 1'b0;
    wait_idle(200, 1'b0);
    exp_q = '{1, 6, 12, 17}; chk_q("hs_start", 0);
    exp_q = '{10, 21};   chk_q("hs_done", 2);

    // Abort: reset sampled at the end of cycle 4 of a delay=10 pair.
    fire(10, 0, 1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_pair_cnt", 32'(pair_cnt), 0);
    repeat (15) @(negedge clk);
    exp_q = '{};         chk_q("abort_stop", 1);

    run(4095, 4095, 2);
    exp_q = '{1, 8193};  chk_q("max_start", 0);
    exp_q = '{4096, 12288}; chk_q("max_stop", 1);
    exp_q = '{12290};    chk_q("max_done", 2);
    chk("max_pair_cnt", 32'(pair_cnt), 2);

    for (int i = 0; i < 40; i++) begin
      fire($urandom_range(0, 9), $urandom_range(0, 5), $urandom_range(0, 4));
      if ($urandom_range(0, 9) == 0) begin
        repeat ($urandom_range(0, 6)) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
      wait_idle(2000, 1'b1);
      if ($urandom_range(0, 1) == 0) @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
